mdu_scoreboard: RTL and testbench
=================================

# mdu_scoreboard

Issue scheduler and hazard controller for the multi-cycle multiply/divide unit (MDU) in the 5-stage pipeline. Tracks the single outstanding MDU operation, stalls ID on load-use and on RAW/WAW hazards against the pending MDU destination, and shares the register-file write port between normal WB traffic and the returning MDU result. Sits beside the forwarding logic at the ID/EX boundary and drives the same stall path as hazard detection.

## Interface
- MAX_CYCLES, 34, watchdog limit in BUSY cycles; legal 2..255
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- ID_Rs1_i  in  5  source 1 of instruction in ID
- ID_Rs2_i  in  5  source 2 of instruction in ID
- ID_RsUse_i  in  2  bit0: ID reads rs1; bit1: ID reads rs2
- ID_Rd_i  in  5  destination of instruction in ID
- ID_RegWrite_i  in  1  ID instruction writes rd; already qualified by valid/flush
- ID_MduReq_i  in  1  ID instruction is an MDU op; already qualified by valid/flush
- EX_MemRead_i  in  1  EX instruction is a load
- EX_Rd_i  in  5  EX destination
- WB_RegWrite_i  in  1  WB stage uses the write port this cycle
- MDU_Done_i  in  1  MDU result valid; held until granted
- MDU_Start_o  out  1  one-cycle issue pulse to MDU
- MDU_WbGrant_o  out  1  MDU result writes the register file this cycle
- MDU_Rd_o  out  5  pending MDU destination
- Stall_o  out  1  hold PC and IF/ID, inject bubble into ID/EX
- Busy_o  out  1  state != IDLE
- Timeout_o  out  1  sticky watchdog error

## Operation
- States: IDLE, BUSY, WBWAIT. Registers: state, pend_rd[4:0], cnt[7:0], Timeout_o.
- use1 = ID_RsUse_i[0]; use2 = ID_RsUse_i[1].
- loaduse = EX_MemRead_i & EX_Rd_i!=0 & ((use1 & ID_Rs1_i==EX_Rd_i) | (use2 & ID_Rs2_i==EX_Rd_i)).
- mduhaz = Busy_o & pend_rd!=0 & ((use1 & ID_Rs1_i==pend_rd) | (use2 & ID_Rs2_i==pend_rd) | (ID_RegWrite_i & ID_Rd_i==pend_rd)).
- Stall_o = loaduse | mduhaz | (Busy_o & ID_MduReq_i) | state==WBWAIT.
- MDU_Start_o = state==IDLE & ID_MduReq_i & !loaduse (combinational).
- IDLE: on MDU_Start_o capture pend_rd<=ID_Rd_i, cnt<=0, go BUSY.
- BUSY: cnt<=cnt+1; MDU_Done_i -> WBWAIT (done has priority over watchdog in the same cycle).
- WBWAIT: MDU_WbGrant_o = !WB_RegWrite_i (combinational); on grant -> IDLE, pend_rd<=0. Stalling guarantees WB drains within 3 cycles, so grant always arrives.
- MDU_Rd_o = pend_rd; Busy_o = state!=IDLE.
- Op with rd=x0: runs and is granted normally; never causes mduhaz.
- No new issue in the grant cycle; the next MDU op issues no earlier than the following cycle.

## Timing
- Reset (async, rst_i=0): state IDLE, pend_rd 0, cnt 0, Timeout_o 0; all outputs 0. Reset mid-operation abandons the op; MDU shares rst_i.
- Issue: MDU_Start_o in cycle T; Busy_o=1 from T+1.
- Done at T+k: WBWAIT from T+k+1; grant earliest T+k+1; IDLE and Stall release at T+k+2 if hazard-free.
- Stall_o, MDU_Start_o, MDU_WbGrant_o are combinational from inputs and state.

## Configuration
- MDU_TIMEOUT_EN defined: in BUSY, if cnt==MAX_CYCLES-1 and !MDU_Done_i, set Timeout_o (sticky until reset), clear pend_rd, go IDLE.
- Undefined: no watchdog check; BUSY waits indefinitely for MDU_Done_i; Timeout_o tied 0. cnt may be omitted.

## Test plan
- Load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_Rs1_i=5, use1=1 -> Stall_o=1 for that cycle, MDU_Start_o=0 even with ID_MduReq_i=1.
- Issue + RAW: MDU op rd=7 issued, next ID reads x7 -> Stall_o=1 until cycle after grant; MDU_Rd_o=7 throughout BUSY/WBWAIT.
- Write-port arbitration: MDU_Done_i=1 while WB_RegWrite_i=1 for 2 cycles -> MDU_WbGrant_o=0 for those cycles, 1 on the first cycle WB_RegWrite_i=0, then IDLE.
- Back-to-back MDU ops: second ID_MduReq_i during BUSY -> stalled; MDU_Start_o pulses one cycle after the first op's grant.
- rd=x0 op: ID reads x0 during BUSY -> no mduhaz stall; grant still issued.
- MDU_TIMEOUT_EN, MAX_CYCLES=4, no done -> Timeout_o=1 after 4 BUSY cycles, Busy_o=0 next; async rst_i low mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_scoreboard.sv
// ============================================================================
// mdu_scoreboard
// ----------------------------------------------------------------------------
// Issue scheduler and hazard controller for the multi-cycle multiply/divide
// unit. Tracks the single outstanding MDU operation, stalls ID on load-use
// and on RAW/WAW hazards against the pending MDU destination, and shares the
// register-file write port between normal WB traffic and the MDU result.
//
// Optional feature macro: MDU_TIMEOUT_EN
//   defined   -> BUSY watchdog; after MAX_CYCLES BUSY cycles without
//                MDU_Done_i the op is abandoned and Timeout_o is set (sticky).
//   undefined -> BUSY waits indefinitely; Timeout_o is tied to 0.
//
// Parameters:
//   MAX_CYCLES     watchdog limit in BUSY cycles (2..255)
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset
//   ID_Rs1_i/Rs2_i ID source registers; ID_RsUse_i[0]/[1] say which are read
//   ID_Rd_i        ID destination; ID_RegWrite_i says it is written
//   ID_MduReq_i    ID instruction is an MDU op
//   EX_MemRead_i   EX instruction is a load; EX_Rd_i its destination
//   WB_RegWrite_i  normal WB traffic owns the write port this cycle
//   MDU_Done_i     MDU result valid, held until granted
//   MDU_Start_o    one-cycle issue pulse to the MDU
//   MDU_WbGrant_o  MDU result writes the register file this cycle
//   MDU_Rd_o       pending MDU destination
//   Stall_o        hold PC and IF/ID, bubble into ID/EX
//   Busy_o         an MDU op is outstanding
//   Timeout_o      sticky watchdog error
// ============================================================================
module mdu_scoreboard #(
    parameter int MAX_CYCLES = 34
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ID_Rs1_i,
    input  logic [4:0] ID_Rs2_i,
    input  logic [1:0] ID_RsUse_i,
    input  logic [4:0] ID_Rd_i,
    input  logic       ID_RegWrite_i,
    input  logic       ID_MduReq_i,
    input  logic       EX_MemRead_i,
    input  logic [4:0] EX_Rd_i,
    input  logic       WB_RegWrite_i,
    input  logic       MDU_Done_i,
    output logic       MDU_Start_o,
    output logic       MDU_WbGrant_o,
    output logic [4:0] MDU_Rd_o,
    output logic       Stall_o,
    output logic       Busy_o,
    output logic       Timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        WBWAIT = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_pend_rd;
    logic [4:0] w_pend_rd_next;

    logic w_use1;
    logic w_use2;
    logic w_busy;
    logic w_loaduse;
    logic w_mduhaz;
    logic w_start;
    logic w_grant;

`ifdef MDU_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic       r_timeout;
    logic       w_timeout_set;
`else
    logic [7:0] w_unused_cfg;
    assign w_unused_cfg = CNT_LAST;
`endif

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_use1 = ID_RsUse_i[0];
    assign w_use2 = ID_RsUse_i[1];
    assign w_busy = (r_state != IDLE);

    assign w_loaduse = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                       ((w_use1 && (ID_Rs1_i == EX_Rd_i)) ||
                        (w_use2 && (ID_Rs2_i == EX_Rd_i)));

    // pend_rd==0 covers both "no op pending" and "op targets x0".
    assign w_mduhaz = w_busy && (r_pend_rd != 5'd0) &&
                      ((w_use1 && (ID_Rs1_i == r_pend_rd)) ||
                       (w_use2 && (ID_Rs2_i == r_pend_rd)) ||
                       (ID_RegWrite_i && (ID_Rd_i == r_pend_rd)));

    assign w_start = (r_state == IDLE) && ID_MduReq_i && !w_loaduse;
    assign w_grant = (r_state == WBWAIT) && !WB_RegWrite_i;

    // Combinational outputs are forced low while reset is asserted so the
    // whole output bundle is quiet during reset, not just the registers.
    assign MDU_Start_o   = rst_i && w_start;
    assign MDU_WbGrant_o = rst_i && w_grant;
    assign Stall_o       = rst_i && (w_loaduse || w_mduhaz ||
                                     (w_busy && ID_MduReq_i) ||
                                     (r_state == WBWAIT));
    assign Busy_o        = w_busy;
    assign MDU_Rd_o      = r_pend_rd;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_pend_rd_next = r_pend_rd;
`ifdef MDU_TIMEOUT_EN
        w_cnt_next     = r_cnt;
        w_timeout_set  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next   = BUSY;
                    w_pend_rd_next = ID_Rd_i;
`ifdef MDU_TIMEOUT_EN
                    w_cnt_next     = 8'd0;
`endif
                end
            end
            BUSY: begin
`ifdef MDU_TIMEOUT_EN
                w_cnt_next = r_cnt + 8'd1;
`endif
                // Done wins over the watchdog in the same cycle.
                if (MDU_Done_i) begin
                    w_state_next = WBWAIT;
                end
`ifdef MDU_TIMEOUT_EN
                else if (r_cnt == CNT_LAST) begin
                    w_state_next   = IDLE;
                    w_pend_rd_next = 5'd0;
                    w_timeout_set  = 1'b1;
                end
`endif
            end
            WBWAIT: begin
                if (w_grant) begin
                    w_state_next   = IDLE;
                    w_pend_rd_next = 5'd0;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_pend_rd_next = 5'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_pend_rd <= 5'd0;
        end else begin
            r_state   <= w_state_next;
            r_pend_rd <= w_pend_rd_next;
        end
    end

`ifdef MDU_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign Timeout_o = r_timeout;
`else
    assign Timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_scoreboard.sv
// ============================================================================
// tb_mdu_scoreboard
// ----------------------------------------------------------------------------
// Directed scenarios followed by randomized traffic. Expected values come from
// a transaction-level model of the outstanding MDU op (pending / result-ready
// flags, destination, BUSY-cycle count) evaluated against the hazard rules.
// ============================================================================
module tb_mdu_scoreboard;

    localparam int TB_MAX = 4;
`ifdef MDU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd;
    logic [1:0] id_use;
    logic       id_regwrite, id_mdureq, ex_memread, wb_regwrite, mdu_done;
    logic       mdu_start, mdu_grant, stall, busy, timeout;
    logic [4:0] mdu_rd;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model of the outstanding operation
    bit       m_pending;
    bit       m_ready;
    bit       m_timeout;
    logic [4:0] m_rd;
    int       m_busy_cycles;

    always #5 clk = ~clk;

    mdu_scoreboard #(.MAX_CYCLES(TB_MAX)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .ID_Rs1_i      (id_rs1),
        .ID_Rs2_i      (id_rs2),
        .ID_RsUse_i    (id_use),
        .ID_Rd_i       (id_rd),
        .ID_RegWrite_i (id_regwrite),
        .ID_MduReq_i   (id_mdureq),
        .EX_MemRead_i  (ex_memread),
        .EX_Rd_i       (ex_rd),
        .WB_RegWrite_i (wb_regwrite),
        .MDU_Done_i    (mdu_done),
        .MDU_Start_o   (mdu_start),
        .MDU_WbGrant_o (mdu_grant),
        .MDU_Rd_o      (mdu_rd),
        .Stall_o       (stall),
        .Busy_o        (busy),
        .Timeout_o     (timeout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use = 2'b00; id_rd = 5'd0;
        id_regwrite = 1'b0; id_mdureq = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        wb_regwrite = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_ready = 1'b0; m_timeout = 1'b0;
        m_rd = 5'd0; m_busy_cycles = 0;
    endtask

    // Checks every output at the falling edge against the model, then
    // advances the model at the rising edge. Returns at rising edge + 1.
    task automatic do_cycle(input string tag);
        bit lu, hz, e_start, e_grant, e_stall;
        @(negedge clk);
        lu = ex_memread && (ex_rd != 5'd0) &&
             ((id_use[0] && id_rs1 == ex_rd) || (id_use[1] && id_rs2 == ex_rd));
        hz = m_pending && (m_rd != 5'd0) &&
             ((id_use[0] && id_rs1 == m_rd) || (id_use[1] && id_rs2 == m_rd) ||
              (id_regwrite && id_rd == m_rd));
        e_start = !m_pending && id_mdureq && !lu;
        e_grant = m_ready && !wb_regwrite;
        e_stall = lu || hz || (m_pending && id_mdureq) || m_ready;
        chk($sformatf("%s.start", tag),   {7'd0, mdu_start}, {7'd0, e_start});
        chk($sformatf("%s.grant", tag),   {7'd0, mdu_grant}, {7'd0, e_grant});
        chk($sformatf("%s.stall", tag),   {7'd0, stall},     {7'd0, e_stall});
        chk($sformatf("%s.busy", tag),    {7'd0, busy},      {7'd0, m_pending});
        chk($sformatf("%s.rd", tag),      {3'd0, mdu_rd},    {3'd0, (m_pending ? m_rd : 5'd0)});
        chk($sformatf("%s.timeout", tag), {7'd0, timeout},   {7'd0, m_timeout});
        @(posedge clk);
        if (e_start) begin
            m_pending = 1'b1; m_ready = 1'b0; m_rd = id_rd; m_busy_cycles = 0;
        end else if (m_pending && !m_ready) begin
            m_busy_cycles++;
            if (mdu_done) m_ready = 1'b1;
            else if (TO_EN && m_busy_cycles == TB_MAX) begin
                m_pending = 1'b0; m_timeout = 1'b1;
            end
        end else if (e_grant) begin
            m_pending = 1'b0; m_ready = 1'b0;
        end
        #1;
    endtask

    initial begin
        // ---------------- reset: all outputs low even with hazardous inputs
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        id_mdureq = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use = 2'b01;
        #3;
        chk("rst.start", {7'd0, mdu_start}, 8'd0);
        chk("rst.stall", {7'd0, stall}, 8'd0);
        chk("rst.grant", {7'd0, mdu_grant}, 8'd0);
        chk("rst.busy", {7'd0, busy}, 8'd0);
        chk("rst.rd", {3'd0, mdu_rd}, 8'd0);
        chk("rst.timeout", {7'd0, timeout}, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- load-use blocks issue
        id_rd = 5'd9;
        #2;
        chk("lu.stall", {7'd0, stall}, 8'd1);
        chk("lu.start", {7'd0, mdu_start}, 8'd0);
        do_cycle("lu");

        // ---------------- issue rd=7, then RAW on x7
        clear_inputs();
        id_mdureq = 1'b1; id_rd = 5'd7; id_regwrite = 1'b1;
        #2;
        chk("issue.start", {7'd0, mdu_start}, 8'd1);
        do_cycle("issue");
        clear_inputs();
        id_rs1 = 5'd7; id_use = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("raw.rd", {3'd0, mdu_rd}, 8'd7);
            chk("raw.stall", {7'd0, stall}, 8'd1);
            do_cycle("raw");
        end
        mdu_done = 1'b1;
        do_cycle("raw_done");
        // ---------------- write-port arbitration
        wb_regwrite = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("arb.grant_blocked", {7'd0, mdu_grant}, 8'd0);
            chk("arb.rd", {3'd0, mdu_rd}, 8'd7);
            do_cycle("arb_wb");
        end
        wb_regwrite = 1'b0;
        #2;
        chk("arb.grant", {7'd0, mdu_grant}, 8'd1);
        chk("arb.stall", {7'd0, stall}, 8'd1);
        do_cycle("arb_grant");
        mdu_done = 1'b0;
        #2;
        chk("raw.release", {7'd0, stall}, 8'd0);
        chk("raw.idle", {7'd0, busy}, 8'd0);
        do_cycle("raw_release");

        // ---------------- back-to-back MDU ops
        clear_inputs();
        id_mdureq = 1'b1; id_rd = 5'd3;
        do_cycle("b2b_issue1");
        id_rd = 5'd4;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("b2b.stall", {7'd0, stall}, 8'd1);
            chk("b2b.nostart", {7'd0, mdu_start}, 8'd0);
            do_cycle("b2b_wait");
        end
        mdu_done = 1'b1;
        do_cycle("b2b_done");
        #2;
        chk("b2b.grant_nostart", {7'd0, mdu_start}, 8'd0);
        do_cycle("b2b_grant");
        mdu_done = 1'b0;
        #2;
        chk("b2b.start2", {7'd0, mdu_start}, 8'd1);
        do_cycle("b2b_issue2");
        id_mdureq = 1'b0;
        mdu_done = 1'b1;
        do_cycle("b2b_done2");
        do_cycle("b2b_grant2");
        mdu_done = 1'b0;

        // ---------------- op with rd=x0 never causes mduhaz
        clear_inputs();
        id_mdureq = 1'b1; id_rd = 5'd0;
        do_cycle("x0_issue");
        id_mdureq = 1'b0; id_use = 2'b11; id_regwrite = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("x0.nostall", {7'd0, stall}, 8'd0);
            chk("x0.busy", {7'd0, busy}, 8'd1);
            do_cycle("x0_busy");
        end
        mdu_done = 1'b1;
        do_cycle("x0_done");
        #2;
        chk("x0.grant", {7'd0, mdu_grant}, 8'd1);
        do_cycle("x0_grant");

        // ---------------- watchdog
        clear_inputs();
        id_mdureq = 1'b1; id_rd = 5'd12;
        do_cycle("wd_issue");
        id_mdureq = 1'b0;
`ifdef MDU_TIMEOUT_EN
        repeat (TB_MAX) do_cycle("wd_busy");
        #2;
        chk("wd.timeout", {7'd0, timeout}, 8'd1);
        chk("wd.idle", {7'd0, busy}, 8'd0);
        do_cycle("wd_after");
`else
        repeat (10) do_cycle("wd_busy");
        #2;
        chk("wd.still_busy", {7'd0, busy}, 8'd1);
        chk("wd.no_timeout", {7'd0, timeout}, 8'd0);
        mdu_done = 1'b1;
        do_cycle("wd_done");
        do_cycle("wd_grant");
        mdu_done = 1'b0;
`endif

        // ---------------- async reset mid-BUSY
        clear_inputs();
        id_mdureq = 1'b1; id_rd = 5'd13;
        do_cycle("ar_issue");
        id_mdureq = 1'b0; id_rs1 = 5'd13; id_use = 2'b01;
        do_cycle("ar_busy");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.busy", {7'd0, busy}, 8'd0);
        chk("ar.rd", {3'd0, mdu_rd}, 8'd0);
        chk("ar.stall", {7'd0, stall}, 8'd0);
        chk("ar.timeout", {7'd0, timeout}, 8'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- randomized traffic
        for (int i = 0; i < 400; i++) begin
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_use      = 2'($urandom_range(0, 3));
            id_rd       = 5'($urandom_range(0, 7));
            id_regwrite = 1'($urandom_range(0, 1));
            id_mdureq   = ($urandom_range(0, 9) < 3);
            ex_memread  = ($urandom_range(0, 9) < 3);
            ex_rd       = 5'($urandom_range(0, 7));
            wb_regwrite = 1'($urandom_range(0, 1));
            mdu_done    = m_ready ? 1'b1 : (m_pending && ($urandom_range(0, 3) == 0));
            do_cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
